// File: rtl/fir_pkg.sv
// Shared constants, state encoding and reset image for the FIR coefficient loader.
package fir_pkg;

  localparam int NTAPS = 16;
  localparam int CW    = 16;
  localparam int GW    = 20;
  localparam int AW    = 4;
  localparam int CNTW  = 5;

  localparam logic [CW-1:0]   UNITY        = 16'h2000;
  localparam logic [CNTW-1:0] GUARD_CYCLES = 5'd20;
  localparam logic [CNTW-1:0] LAST_PTR     = 5'd15;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    LOADING = 2'd1,
    ARMED   = 2'd2,
    GUARD   = 2'd3
  } state_t;

  // Pass-through filter: unity gain on tap 0, all other taps zero.
  function automatic logic [CW-1:0] reset_tap(input int idx);
    return (idx == 0) ? UNITY : '0;
  endfunction

endpackage

// File: rtl/fir_coeff_bank.sv
// Shadow/active coefficient register file: indexed write into shadow, single-edge
// bulk copy shadow->active, registered readback and parallel output of the active bank.
module fir_coeff_bank
  import fir_pkg::*;
(
  input  logic                clk,
  input  logic                reset,
  input  logic                wr_en,
  input  logic [AW-1:0]       wr_addr,
  input  logic [CW-1:0]       wr_data,
  input  logic                commit,
  input  logic [AW-1:0]       rd_addr,
  output logic [CW-1:0]       rd_data,
  output logic [NTAPS*CW-1:0] active_words
);

  logic [CW-1:0] shadow [NTAPS];
  logic [CW-1:0] active [NTAPS];

  // NOTE: both banks are reset explicitly because the FIR must see a defined
  // pass-through filter after reset; this keeps them in flops, not RAM.
  // NOTE: sequential state uses non-blocking assignments so every tap updates
  // from pre-edge values, which is what makes the commit copy atomic.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NTAPS; i++) begin
        shadow[i] <= reset_tap(i);
        active[i] <= reset_tap(i);
      end
      rd_data <= '0;
    end else begin
      if (wr_en) shadow[wr_addr] <= wr_data;
      if (commit) begin
        for (int i = 0; i < NTAPS; i++) active[i] <= shadow[i];
      end
      rd_data <= active[rd_addr];
    end
  end

  always_comb begin
    active_words = '0;
    for (int i = 0; i < NTAPS; i++) active_words[i*CW +: CW] = active[i];
  end

endmodule

// File: rtl/fir_coeff_loader.sv
// Coefficient loader for a 16-tap FIR: protocol FSM, write pointer, gain accumulator
// and post-commit guard that masks the FIR enable while mixed samples drain.
module fir_coeff_loader
  import fir_pkg::*;
(
  input  logic                clk,
  input  logic                reset,
  input  logic                load_start,
  input  logic                wr_valid,
  input  logic [CW-1:0]       wr_data,
  input  logic                commit,
  input  logic                enable_fir_in,
  input  logic [AW-1:0]       rd_addr,
  output logic [NTAPS*CW-1:0] coeff_bus,
  output logic                enable_fir_out,
  output logic [CW-1:0]       rd_data,
  output logic [1:0]          state,
  output logic [CNTW-1:0]     wr_count,
  output logic [GW-1:0]       gain_sum,
  output logic                err
);

  state_t          cur, nxt;
  logic [CNTW-1:0] guard_cnt;
  logic            wr_accept, commit_accept, err_set;

  // NOTE: every always_comb output gets a default first so no path leaves a
  // signal unassigned and no latch is inferred.
  always_comb begin
    nxt           = cur;
    wr_accept     = 1'b0;
    commit_accept = 1'b0;
    err_set       = 1'b0;
    if (load_start) begin
      nxt = LOADING;
    end else begin
      unique case (cur)
        IDLE: err_set = wr_valid | commit;
        LOADING: begin
          wr_accept = wr_valid;
          err_set   = commit;
          if (wr_valid && wr_count == LAST_PTR) nxt = ARMED;
        end
        ARMED: begin
          err_set = wr_valid;
          if (commit) begin
            commit_accept = 1'b1;
            nxt           = GUARD;
          end
        end
        GUARD: begin
          err_set = wr_valid | commit;
          if (guard_cnt <= 5'd1) nxt = IDLE;
        end
        default: nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cur       <= IDLE;
      wr_count  <= '0;
      gain_sum  <= '0;
      err       <= 1'b0;
      guard_cnt <= '0;
    end else begin
      cur <= nxt;
      if (load_start) begin
        wr_count <= '0;
        gain_sum <= '0;
        err      <= 1'b0;
      end else begin
        if (wr_accept) begin
          wr_count <= wr_count + 5'd1;
          gain_sum <= gain_sum + GW'(wr_data);
        end
        if (err_set) err <= 1'b1;
      end
      // The guard runs down independently of the FSM so a reload can overlap it.
      if (commit_accept)        guard_cnt <= GUARD_CYCLES;
      else if (guard_cnt != '0) guard_cnt <= guard_cnt - 5'd1;
    end
  end

  fir_coeff_bank u_bank (
    .clk          (clk),
    .reset        (reset),
    .wr_en        (wr_accept),
    .wr_addr      (wr_count[AW-1:0]),
    .wr_data      (wr_data),
    .commit       (commit_accept),
    .rd_addr      (rd_addr),
    .rd_data      (rd_data),
    .active_words (coeff_bus)
  );

  assign enable_fir_out = enable_fir_in & (guard_cnt == '0);
  assign state          = cur;

endmodule

// File: tb/tb_fir_coeff_loader.sv
// Scoreboard bench for fir_coeff_loader: stimulus queues expectations with a due cycle,
// a negedge monitor pops and compares them against the DUT outputs.
module tb_fir_coeff_loader;

  logic         clk = 1'b0;
  logic         reset, load_start, wr_valid, commit, enable_fir_in;
  logic [15:0]  wr_data;
  logic [3:0]   rd_addr;
  logic [255:0] coeff_bus;
  logic         enable_fir_out, err;
  logic [15:0]  rd_data;
  logic [1:0]   state;
  logic [4:0]   wr_count;
  logic [19:0]  gain_sum;

  fir_coeff_loader dut (
    .clk            (clk),
    .reset          (reset),
    .load_start     (load_start),
    .wr_valid       (wr_valid),
    .wr_data        (wr_data),
    .commit         (commit),
    .enable_fir_in  (enable_fir_in),
    .rd_addr        (rd_addr),
    .coeff_bus      (coeff_bus),
    .enable_fir_out (enable_fir_out),
    .rd_data        (rd_data),
    .state          (state),
    .wr_count       (wr_count),
    .gain_sum       (gain_sum),
    .err            (err)
  );

  always #5 clk = ~clk;

  typedef enum {F_COEFF, F_EN, F_RD, F_STATE, F_CNT, F_SUM, F_ERR} field_t;
  typedef struct {
    field_t       f;
    string        name;
    logic [255:0] exp;
    int           due;
  } exp_t;

  exp_t sbq[$];
  int   cycle    = 0;
  int   n_checks = 0;
  int   n_fail   = 0;

  always @(posedge clk) cycle <= cycle + 1;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cycle);
    end
  endtask

  always @(negedge clk) begin
    while (sbq.size() != 0 && sbq[0].due <= cycle) begin
      exp_t         e;
      logic [255:0] act;
      e = sbq.pop_front();
      case (e.f)
        F_COEFF: act = coeff_bus;
        F_EN:    act = 256'(enable_fir_out);
        F_RD:    act = 256'(rd_data);
        F_STATE: act = 256'(state);
        F_CNT:   act = 256'(wr_count);
        F_SUM:   act = 256'(gain_sum);
        default: act = 256'(err);
      endcase
      check(e.name, act, e.exp);
    end
  end

  task automatic expect_out(input field_t f, input string name, input logic [255:0] exp,
                            input int dly);
    exp_t e;
    e.f = f; e.name = name; e.exp = exp; e.due = cycle + dly;
    sbq.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_load();
    load_start = 1'b1; tick(); load_start = 1'b0;
  endtask

  task automatic write(input logic [15:0] d);
    wr_valid = 1'b1; wr_data = d; tick(); wr_valid = 1'b0;
  endtask

  task automatic do_commit();
    commit = 1'b1; tick(); commit = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1; tick(); tick(); reset = 1'b0;
  endtask

  localparam logic [255:0] PASS_BANK = {240'h0, 16'h2000};
  localparam logic [255:0] BANK_200  = {16{16'h0200}};
  localparam logic [255:0] BANK_100  = {16{16'h0100}};

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [255:0] ramp;
    ramp = '0;
    for (int i = 0; i < 16; i++) ramp[i*16 +: 16] = 16'(i + 1);

    reset = 1'b1; load_start = 1'b0; wr_valid = 1'b0; commit = 1'b0;
    enable_fir_in = 1'b1; wr_data = '0; rd_addr = '0;
    tick();

    // 1: reset state
    do_reset();
    expect_out(F_COEFF, "rst_coeff", PASS_BANK, 0);
    expect_out(F_EN,    "rst_en",    1, 0);
    expect_out(F_STATE, "rst_state", 0, 0);
    expect_out(F_CNT,   "rst_cnt",   0, 0);
    expect_out(F_SUM,   "rst_sum",   0, 0);
    expect_out(F_ERR,   "rst_err",   0, 0);
    expect_out(F_RD,    "rst_rd",    0, 0);

    // 2: uniform load with gaps, atomic commit, 20-cycle guard
    pulse_load();
    expect_out(F_STATE, "t2_loading", 1, 0);
    for (int i = 0; i < 16; i++) begin
      write(16'h0200);
      if (i % 4 == 3) tick();
    end
    expect_out(F_STATE, "t2_armed", 2, 0);
    expect_out(F_CNT,   "t2_cnt",   16, 0);
    expect_out(F_SUM,   "t2_sum",   20'h02000, 0);
    expect_out(F_COEFF, "t2_pre_commit", PASS_BANK, 0);
    expect_out(F_EN,    "t2_en_pre", 1, 0);
    do_commit();
    expect_out(F_COEFF, "t2_post_commit", BANK_200, 0);
    expect_out(F_STATE, "t2_guard", 3, 0);
    for (int i = 0; i < 20; i++) begin
      expect_out(F_EN, $sformatf("t2_guard_en%0d", i), 0, 0);
      tick();
    end
    expect_out(F_EN,    "t2_en_back", 1, 0);
    expect_out(F_STATE, "t2_idle",    0, 0);

    // 3: partial load, restart (coincident word dropped), ramp load; readback sees old bank
    pulse_load();
    for (int i = 0; i < 8; i++) write(16'hAAAA);
    expect_out(F_CNT, "t3_partial_cnt", 8, 0);
    load_start = 1'b1; wr_valid = 1'b1; wr_data = 16'h5555;
    tick();
    load_start = 1'b0; wr_valid = 1'b0;
    expect_out(F_CNT, "t3_restart_cnt", 0, 0);
    expect_out(F_SUM, "t3_restart_sum", 0, 0);
    expect_out(F_ERR, "t3_restart_err", 0, 0);
    for (int i = 0; i < 16; i++) begin
      rd_addr = 4'(i);
      expect_out(F_RD, $sformatf("t3_rd_old%0d", i), 16'h0200, 1);
      write(16'(i + 1));
    end
    expect_out(F_SUM,   "t3_sum",   136, 0);
    expect_out(F_CNT,   "t3_cnt",   16, 0);
    expect_out(F_ERR,   "t3_err",   0, 0);
    expect_out(F_STATE, "t3_armed", 2, 0);
    do_commit();
    expect_out(F_COEFF, "t3_ramp", ramp, 0);
    repeat (20) tick();
    expect_out(F_STATE, "t3_idle", 0, 0);

    // 6: readback sweep of the active bank
    for (int a = 0; a < 16; a++) begin
      rd_addr = 4'(a);
      expect_out(F_RD, $sformatf("t6_rd%0d", a), 16'(a + 1), 1);
      tick();
    end
    tick();

    // 4: extra word in ARMED dropped, commit in IDLE rejected
    pulse_load();
    for (int i = 0; i < 16; i++) write(16'h0100);
    expect_out(F_ERR, "t4_err_clean", 0, 0);
    write(16'hFFFF);
    expect_out(F_ERR,   "t4_err_extra", 1, 0);
    expect_out(F_STATE, "t4_still_armed", 2, 0);
    expect_out(F_CNT,   "t4_cnt", 16, 0);
    expect_out(F_SUM,   "t4_sum", 20'h01000, 0);
    do_commit();
    expect_out(F_COEFF, "t4_bank", BANK_100, 0);
    repeat (20) tick();
    expect_out(F_STATE, "t4_idle", 0, 0);
    do_commit();
    expect_out(F_COEFF, "t4_idle_commit_bank", BANK_100, 0);
    expect_out(F_ERR,   "t4_idle_commit_err", 1, 0);
    expect_out(F_STATE, "t4_idle_commit_state", 0, 0);

    // 5a: reset mid-load; LOAD_START clears ERR first
    pulse_load();
    expect_out(F_ERR, "t5_load_clears_err", 0, 0);
    for (int i = 0; i < 9; i++) write(16'h0300);
    expect_out(F_CNT, "t5_cnt9", 9, 0);
    reset = 1'b1; tick(); reset = 1'b0;
    expect_out(F_COEFF, "t5a_coeff", PASS_BANK, 0);
    expect_out(F_STATE, "t5a_state", 0, 0);
    expect_out(F_CNT,   "t5a_cnt",   0, 0);
    expect_out(F_SUM,   "t5a_sum",   0, 0);

    // 5b: reset with guard counter at 5
    pulse_load();
    for (int i = 0; i < 16; i++) write(16'h0400);
    do_commit();
    repeat (15) tick();
    expect_out(F_EN,    "t5b_en_guard", 0, 0);
    expect_out(F_COEFF, "t5b_bank", {16{16'h0400}}, 0);
    reset = 1'b1; tick(); reset = 1'b0;
    expect_out(F_COEFF, "t5b_coeff", PASS_BANK, 0);
    expect_out(F_STATE, "t5b_state", 0, 0);
    expect_out(F_CNT,   "t5b_cnt",   0, 0);
    expect_out(F_EN,    "t5b_en",    1, 0);

    tick(); tick();
    check("sb_drain", 256'(sbq.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
